branch_resolve_ctrl: RTL
========================

Name: branch_resolve_ctrl

Overview:
- Decode-stage controller that sequences the branch comparer.
- Detects branch/jump instructions in ID, stalls ID until operands are forwarded, drives the comparer, and computes the target.
- Honours the MIPS delay slot, then hands a redirect to fetch through a valid/ready handshake.
- Keeps branch and taken statistics for perf test runs.

Parameters:
- CNT_W, 32: width of the statistics counters (wrap on overflow).
- DS_EN, 1: 1 = wait for the delay slot to be fetched before redirect; 0 = redirect right after resolve.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  exception/eret flush; synchronous, highest priority
- id_valid  in  1  ID holds a valid instruction
- id_op  in  6  opcode
- id_rt  in  5  rt field
- id_funct  in  6  funct field
- id_imm  in  26  instr[25:0]
- id_pc  in  32  PC of the ID instruction
- rs_data, rt_data  in  32 each  forwarded operands
- rs_ready, rt_ready  in  1 each  operands valid from the hazard unit
- cmp_a, cmp_b  out  32 each  to comparer a/b; combinational copy of rs_data/rt_data
- cmp_op, cmp_rt  out  6/5  to comparer op/rt; copy of id_op/id_rt
- cmp_y  in  1  comparer result, combinational
- ds_fetched  in  1  level: delay-slot instruction has been fetched
- stall_id  out  1  hold the IF/ID stages
- redir_valid  out  1  redirect request, registered
- redir_pc  out  32  redirect target, registered
- redir_ready  in  1  fetch accepts the redirect
- br_resolved  out  1  one-cycle pulse, registered
- br_taken  out  1  qualifies br_resolved
- br_cnt, taken_cnt  out  CNT_W each  statistics

Behaviour:
- Instruction decode, active only when id_valid=1:
  - Conditional branches: op 000100 BEQ, 000101 BNE, 000110 BLEZ, 000111 BGTZ.
  - REGIMM (op 000001) branches when rt is one of 00000, 00001, 10000, 10001. Any other rt is not a branch.
  - J 000010 and JAL 000011: always taken, no operands needed.
  - op 000000 with funct 001000 JR or 001001 JALR: always taken, need rs only.
- Operand readiness:
  - BEQ/BNE need rs_ready and rt_ready.
  - Other conditional branches and JR/JALR need rs_ready.
  - J/JAL are always ready.
- Target address (pc4 = id_pc+4, 32-bit wrap):
  - Conditional branches: pc4 + (sign_ext(imm[15:0]) << 2).
  - J/JAL: {pc4[31:28], imm, 2'b00}.
  - JR/JALR: rs_data.
- Taken: cmp_y for conditional branches, 1 for jumps.
- FSM states: IDLE, WAIT_OPND, WAIT_DS, REDIRECT. Reset and flush both force IDLE.
- IDLE / WAIT_OPND, branch present and ready:
  - Resolve at the clock edge: br_resolved=1 and br_taken=taken in the next cycle; br_cnt+1; taken_cnt+1 if taken.
  - Not taken: go to IDLE.
  - Taken: latch the target; go to REDIRECT if DS_EN=0 or ds_fetched=1 this cycle, else WAIT_DS.
- IDLE / WAIT_OPND, branch present but not ready: stall_id=1 combinationally; go to (or stay in) WAIT_OPND.
- WAIT_OPND with id_valid=0 or no branch in ID: return to IDLE, no resolve, no count.
- WAIT_DS: stall_id=0 so the delay slot proceeds; go to REDIRECT on the first cycle ds_fetched=1.
- REDIRECT:
  - redir_valid=1 and redir_pc=latched target, both stable until redir_ready.
  - The handshake completes in the cycle with redir_valid and redir_ready both high; next state IDLE, redir_valid=0.
  - Back-to-back: a branch in ID in the handshake cycle is not evaluated that cycle.
- WAIT_DS / REDIRECT: branches in ID (delay-slot branches) are ignored; stall_id=0.
- flush:
  - Next edge: state IDLE, redir_valid=0, no br_resolved pulse, counters unchanged.
  - stall_id is forced to 0 in the flush cycle.
  - flush overrides a simultaneous resolve or handshake.
- rst mid-operation: everything returns to reset values immediately.
- Reset values: redir_valid=0, redir_pc=0, br_resolved=0, br_taken=0, br_cnt=0, taken_cnt=0, state IDLE.
- Latency, ready branch at cycle N:
  - br_resolved at N+1.
  - Earliest redir_valid at N+1 (DS_EN=0, or ds_fetched high at N).
- Counters wrap: all-ones + 1 = 0.

Test Plan:
- BEQ at id_pc=0x00400010, imm=0x0004, rs=rt=5, both ready, ds_fetched=1, redir_ready=1 -> br_resolved/br_taken=1 at N+1; redir_pc=0x00400024; redir_valid for exactly one cycle; br_cnt=1, taken_cnt=1.
- BNE with rs=rt=7 -> br_taken=0, no redir_valid, br_cnt=1, taken_cnt=0.
- BGTZ with rs_ready=0 for 3 cycles -> stall_id=1 for those 3 cycles, state WAIT_OPND; resolves on the ready cycle; a negative imm 0xFFFC at pc=0x100 gives target 0x000000F4.
- JAL at pc=0xBFC00000, imm=0x0100000, ds_fetched low 2 cycles, then redir_ready low 2 cycles -> redirect waits for ds_fetched; redir_pc=0xB0400000 held stable through the backpressure.
- JR with rs=0x80001234 in REDIRECT, flush asserted simultaneously with redir_ready -> IDLE next cycle, redir_valid=0, no further redirect.
- REGIMM with rt=00011 -> not a branch: no stall, no resolve. BLTZAL with rs=0xFFFFFFFF -> taken. Preload-style run of 2^CNT_W branches (CNT_W=4 variant) -> br_cnt wraps to 0.

Source files
------------

// File: rtl/branch_resolve_ctrl_if.sv
// Redirect handshake from the branch resolver to fetch.
// The resolver is the master; fetch accepts with redir_ready.
interface branch_resolve_ctrl_if;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;

    modport master (output redir_valid, output redir_pc, input redir_ready);
    modport slave  (input redir_valid, input redir_pc, output redir_ready);
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch/jump controller: waits for operands, resolves through
// the external comparer, honours the delay slot and redirects fetch.
module branch_resolve_ctrl #(
    parameter int CNT_W = 32,
    parameter bit DS_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [5:0]            id_op,
    input  logic [4:0]            id_rt,
    input  logic [5:0]            id_funct,
    input  logic [25:0]           id_imm,
    input  logic [31:0]           id_pc,
    input  logic [31:0]           rs_data,
    input  logic [31:0]           rt_data,
    input  logic                  rs_ready,
    input  logic                  rt_ready,
    output logic [31:0]           cmp_a,
    output logic [31:0]           cmp_b,
    output logic [5:0]            cmp_op,
    output logic [4:0]            cmp_rt,
    input  logic                  cmp_y,
    input  logic                  ds_fetched,
    output logic                  stall_id,
    branch_resolve_ctrl_if.master redir,
    output logic                  br_resolved,
    output logic                  br_taken,
    output logic [CNT_W-1:0]      br_cnt,
    output logic [CNT_W-1:0]      taken_cnt
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_OPND,
        WAIT_DS,
        REDIRECT
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      target_q, target_d;
    logic             redir_valid_q, redir_valid_d;
    logic             br_resolved_q, br_resolved_d;
    logic             br_taken_q, br_taken_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic        is_cond, need_rt, is_jump, is_jreg;
    logic        is_branch, opnd_ready, taken_now;
    logic [31:0] pc4, target_now;

    assign cmp_a  = rs_data;
    assign cmp_b  = rt_data;
    assign cmp_op = id_op;
    assign cmp_rt = id_rt;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        is_cond = 1'b0;
        need_rt = 1'b0;
        is_jump = 1'b0;
        is_jreg = 1'b0;
        case (id_op)
            OP_BEQ, OP_BNE: begin
                is_cond = 1'b1;
                need_rt = 1'b1;
            end
            OP_BLEZ, OP_BGTZ: is_cond = 1'b1;
            OP_REGIMM: is_cond = (id_rt == 5'b00000) || (id_rt == 5'b00001) ||
                                 (id_rt == 5'b10000) || (id_rt == 5'b10001);
            OP_J, OP_JAL:     is_jump = 1'b1;
            OP_SPECIAL:       is_jreg = (id_funct == FN_JR) || (id_funct == FN_JALR);
            default: ;
        endcase
    end

    assign is_branch  = id_valid && (is_cond || is_jump || is_jreg);
    assign opnd_ready = is_jump || (rs_ready && (!need_rt || rt_ready));
    assign taken_now  = is_cond ? cmp_y : 1'b1;
    assign pc4        = id_pc + 32'd4;

    always_comb begin
        if (is_jump) begin
            target_now = {pc4[31:28], id_imm, 2'b00};
        end else if (is_jreg) begin
            target_now = rs_data;
        end else begin
            target_now = pc4 + {{14{id_imm[15]}}, id_imm[15:0], 2'b00};
        end
    end

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        br_resolved_d = 1'b0;
        br_taken_d    = 1'b0;
        br_cnt_d      = br_cnt_q;
        taken_cnt_d   = taken_cnt_q;
        stall_id      = 1'b0;

        // A flush drops any pending redirect and suppresses resolve and stall.
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, WAIT_OPND: begin
                    if (!is_branch) begin
                        state_d = IDLE;
                    end else if (!opnd_ready) begin
                        stall_id = 1'b1;
                        state_d  = WAIT_OPND;
                    end else begin
                        br_resolved_d = 1'b1;
                        br_taken_d    = taken_now;
                        br_cnt_d      = br_cnt_q + CNT_W'(1);
                        taken_cnt_d   = taken_cnt_q + CNT_W'(taken_now);
                        if (!taken_now) begin
                            state_d = IDLE;
                        end else begin
                            target_d = target_now;
                            state_d  = (!DS_EN || ds_fetched) ? REDIRECT : WAIT_DS;
                        end
                    end
                end
                WAIT_DS: begin
                    if (ds_fetched) begin
                        state_d = REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (redir.redir_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign redir_valid_d = (state_d == REDIRECT);

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            target_q      <= '0;
            redir_valid_q <= 1'b0;
            br_resolved_q <= 1'b0;
            br_taken_q    <= 1'b0;
            br_cnt_q      <= '0;
            taken_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            redir_valid_q <= redir_valid_d;
            br_resolved_q <= br_resolved_d;
            br_taken_q    <= br_taken_d;
            br_cnt_q      <= br_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
        end
    end

    assign redir.redir_valid = redir_valid_q;
    assign redir.redir_pc    = target_q;
    assign br_resolved       = br_resolved_q;
    assign br_taken          = br_taken_q;
    assign br_cnt            = br_cnt_q;
    assign taken_cnt         = taken_cnt_q;

endmodule
